// File: rtl/l1_l2_arbiter.sv
// Shares one L2 port between the L1 I-cache and D-cache controllers with round-robin
// grants; the winning command, address and write data are latched and held until L2 completes.
module l1_l2_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              read_I_L2,
  input  logic [ADDR_W-1:0] addr_I_L2,
  output logic              ready_L2_I,
  output logic [LINE_W-1:0] data_L2_I,
  input  logic              read_D_L2,
  input  logic              write_D_L2,
  input  logic [ADDR_W-1:0] addr_D_L2,
  input  logic [LINE_W-1:0] wdata_D_L2,
  output logic              ready_L2_D,
  output logic [LINE_W-1:0] data_L2_D,
  output logic              read_L1_L2,
  output logic              write_L1_L2,
  output logic [ADDR_W-1:0] addr_L1_L2,
  output logic [LINE_W-1:0] wdata_L1_L2,
  input  logic              ready_L2_L1,
  input  logic [LINE_W-1:0] rdata_L2_L1,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT_I = 2'd1,
    S_GRANT_D = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t            state_r;
  logic              last_r;
  logic              owner_r;
  logic              busy_r;
  logic              read_r;
  logic              write_r;
  logic [ADDR_W-1:0] addr_r;
  logic [LINE_W-1:0] wdata_r;

  logic              req_i_s;
  logic              req_d_s;
  logic              any_req_s;
  logic              pick_d_s;

  // Request decode and round-robin choice; on a tie the requester that did not win last time goes.
  always_comb begin
    req_i_s   = read_I_L2;
    req_d_s   = read_D_L2 | write_D_L2;
    any_req_s = req_i_s | req_d_s;
    if (req_i_s && req_d_s) begin
      pick_d_s = ~last_r;
    end else begin
      pick_d_s = req_d_s;
    end
  end

  // Arbitration FSM with registered command, latch, busy and owner outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r <= S_IDLE;
      last_r  <= 1'b0;
      owner_r <= 1'b0;
      busy_r  <= 1'b0;
      read_r  <= 1'b0;
      write_r <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= {LINE_W{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (any_req_s) begin
            busy_r  <= 1'b1;
            owner_r <= pick_d_s;
            last_r  <= pick_d_s;
            if (pick_d_s) begin
              state_r <= S_GRANT_D;
              addr_r  <= addr_D_L2;
              wdata_r <= wdata_D_L2;
              // A D request with both read and write set resolves to the write-back.
              write_r <= write_D_L2;
              read_r  <= ~write_D_L2;
            end else begin
              state_r <= S_GRANT_I;
              addr_r  <= addr_I_L2;
              write_r <= 1'b0;
              read_r  <= 1'b1;
            end
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_GRANT_I, S_GRANT_D: begin
          if (ready_L2_L1) begin
            state_r <= S_RELEASE;
            read_r  <= 1'b0;
            write_r <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end
        S_RELEASE: begin
          // One dead cycle so a registered L1 request that drops a cycle late is not re-granted.
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
          read_r  <= 1'b0;
          write_r <= 1'b0;
        end
      endcase
    end
  end

  // Zero-latency completion routing; only the current owner ever sees ready or data.
  always_comb begin
    ready_L2_I = ready_L2_L1 & (state_r == S_GRANT_I);
    ready_L2_D = ready_L2_L1 & (state_r == S_GRANT_D);
    if (state_r == S_GRANT_I) begin
      data_L2_I = rdata_L2_L1;
    end else begin
      data_L2_I = {LINE_W{1'b0}};
    end
    if (state_r == S_GRANT_D) begin
      data_L2_D = rdata_L2_L1;
    end else begin
      data_L2_D = {LINE_W{1'b0}};
    end
  end

  assign read_L1_L2  = read_r;
  assign write_L1_L2 = write_r;
  assign addr_L1_L2  = addr_r;
  assign wdata_L1_L2 = wdata_r;
  assign busy        = busy_r;
  assign owner       = owner_r;

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Self-checking bench for l1_l2_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level reference model.
module tb_l1_l2_arbiter;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 128;

  logic              clk = 1'b0;
  logic              nrst;
  logic              read_I_L2;
  logic [ADDR_W-1:0] addr_I_L2;
  logic              ready_L2_I;
  logic [LINE_W-1:0] data_L2_I;
  logic              read_D_L2;
  logic              write_D_L2;
  logic [ADDR_W-1:0] addr_D_L2;
  logic [LINE_W-1:0] wdata_D_L2;
  logic              ready_L2_D;
  logic [LINE_W-1:0] data_L2_D;
  logic              read_L1_L2;
  logic              write_L1_L2;
  logic [ADDR_W-1:0] addr_L1_L2;
  logic [LINE_W-1:0] wdata_L1_L2;
  logic              ready_L2_L1;
  logic [LINE_W-1:0] rdata_L2_L1;
  logic              busy;
  logic              owner;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  l1_l2_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .nrst(nrst),
    .read_I_L2(read_I_L2), .addr_I_L2(addr_I_L2), .ready_L2_I(ready_L2_I), .data_L2_I(data_L2_I),
    .read_D_L2(read_D_L2), .write_D_L2(write_D_L2), .addr_D_L2(addr_D_L2), .wdata_D_L2(wdata_D_L2),
    .ready_L2_D(ready_L2_D), .data_L2_D(data_L2_D),
    .read_L1_L2(read_L1_L2), .write_L1_L2(write_L1_L2), .addr_L1_L2(addr_L1_L2),
    .wdata_L1_L2(wdata_L1_L2), .ready_L2_L1(ready_L2_L1), .rdata_L2_L1(rdata_L2_L1),
    .busy(busy), .owner(owner)
  );

  function automatic logic [LINE_W-1:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic drive_quiet();
    read_I_L2   = 1'b0;
    addr_I_L2   = 32'h0;
    read_D_L2   = 1'b0;
    write_D_L2  = 1'b0;
    addr_D_L2   = 32'h0;
    wdata_D_L2  = 128'h0;
    ready_L2_L1 = 1'b0;
    rdata_L2_L1 = 128'h0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    nrst = 1'b0;
    drive_quiet();
    repeat (2) @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    nrst = 1'b0;
    drive_quiet();
    ready_L2_L1 = 1'b1;
    rdata_L2_L1 = rand_line();
    #1;
    checks++;
    if ({read_L1_L2, write_L1_L2, busy, owner, ready_L2_I, ready_L2_D} !== 6'b000000) begin
      errors++;
      $display("FAIL reset_ctrl got %b expected 000000",
               {read_L1_L2, write_L1_L2, busy, owner, ready_L2_I, ready_L2_D});
    end
    checks++;
    if (addr_L1_L2 !== 32'h0 || wdata_L1_L2 !== 128'h0 || data_L2_I !== 128'h0 || data_L2_D !== 128'h0) begin
      errors++;
      $display("FAIL reset_data got addr=%h wdata=%h dI=%h dD=%h expected all 0",
               addr_L1_L2, wdata_L1_L2, data_L2_I, data_L2_D);
    end
    ready_L2_L1 = 1'b0;
    rdata_L2_L1 = 128'h0;
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_single_i_read();
    int hold;
    logic [LINE_W-1:0] a5;
    a5 = {16{8'hA5}};
    hold = 0;
    @(negedge clk);
    read_I_L2 = 1'b1;
    addr_I_L2 = 32'h0000_1040;
    #1;
    checks++;
    if (read_L1_L2 !== 1'b0) begin
      errors++;
      $display("FAIL single_no_early_cmd got %b expected 0", read_L1_L2);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 3) begin
        ready_L2_L1 = 1'b1;
        rdata_L2_L1 = a5;
      end
      #1;
      if (read_L1_L2 === 1'b1 && write_L1_L2 === 1'b0) hold++;
      if (k == 0) begin
        checks++;
        if (addr_L1_L2 !== 32'h0000_1040 || owner !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL single_grant got addr=%h owner=%b busy=%b expected 00001040 0 1",
                   addr_L1_L2, owner, busy);
        end
      end
      if (k == 3) begin
        checks++;
        if (ready_L2_I !== 1'b1 || data_L2_I !== a5 || ready_L2_D !== 1'b0 || data_L2_D !== 128'h0) begin
          errors++;
          $display("FAIL single_ready got rI=%b dI=%h rD=%b dD=%h expected 1 %h 0 0",
                   ready_L2_I, data_L2_I, ready_L2_D, data_L2_D, a5);
        end
      end else begin
        checks++;
        if (ready_L2_I !== 1'b0) begin
          errors++;
          $display("FAIL single_early_ready cycle %0d got %b expected 0", k, ready_L2_I);
        end
      end
    end
    checks++;
    if (hold != 4) begin
      errors++;
      $display("FAIL single_cmd_hold got %0d cycles expected 4", hold);
    end
    @(negedge clk);
    ready_L2_L1 = 1'b0;
    rdata_L2_L1 = 128'h0;
    #1;
    checks++;
    if (read_L1_L2 !== 1'b0 || busy !== 1'b1 || ready_L2_I !== 1'b0) begin
      errors++;
      $display("FAIL single_release got rd=%b busy=%b rI=%b expected 0 1 0", read_L1_L2, busy, ready_L2_I);
    end
    @(negedge clk);
    read_I_L2 = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single_busy_fall got %b expected 0", busy);
    end
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || read_L1_L2 !== 1'b0) begin
      errors++;
      $display("FAIL single_no_regrant got busy=%b rd=%b expected 0 0", busy, read_L1_L2);
    end
  endtask

  task automatic test_tie();
    logic exp_d;
    logic [LINE_W-1:0] r;
    apply_reset();
    read_I_L2 = 1'b1;
    addr_I_L2 = 32'h0000_2000;
    read_D_L2 = 1'b1;
    addr_D_L2 = 32'h0000_3000;
    for (int n = 0; n < 3; n++) begin
      exp_d = (n != 1);
      @(negedge clk);
      r = rand_line();
      ready_L2_L1 = 1'b1;
      rdata_L2_L1 = r;
      #1;
      checks++;
      if (owner !== exp_d || read_L1_L2 !== 1'b1 ||
          addr_L1_L2 !== (exp_d ? 32'h0000_3000 : 32'h0000_2000)) begin
        errors++;
        $display("FAIL tie_grant round %0d got owner=%b rd=%b addr=%h expected owner=%b",
                 n, owner, read_L1_L2, addr_L1_L2, exp_d);
      end
      checks++;
      if (ready_L2_D !== exp_d || ready_L2_I !== !exp_d ||
          (exp_d ? data_L2_D : data_L2_I) !== r || (exp_d ? data_L2_I : data_L2_D) !== 128'h0) begin
        errors++;
        $display("FAIL tie_ready round %0d got rI=%b rD=%b expected rD=%b", n, ready_L2_I, ready_L2_D, exp_d);
      end
      @(negedge clk);
      ready_L2_L1 = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b1 || read_L1_L2 !== 1'b0) begin
        errors++;
        $display("FAIL tie_release round %0d got busy=%b rd=%b expected 1 0", n, busy, read_L1_L2);
      end
      @(negedge clk);
      #1;
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL tie_idle round %0d got busy=%b expected 0", n, busy);
      end
    end
    read_I_L2 = 1'b0;
    read_D_L2 = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL tie_quiet got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_wb_refill();
    int stable;
    logic [LINE_W-1:0] wd;
    logic [LINE_W-1:0] r;
    stable = 0;
    wd = 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321;
    @(negedge clk);
    write_D_L2 = 1'b1;
    addr_D_L2  = 32'h0000_4080;
    wdata_D_L2 = wd;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      wdata_D_L2 = rand_line();
      if (k == 3) ready_L2_L1 = 1'b1;
      #1;
      if (write_L1_L2 === 1'b1 && read_L1_L2 === 1'b0 && wdata_L1_L2 === wd && addr_L1_L2 === 32'h0000_4080)
        stable++;
    end
    checks++;
    if (stable != 4 || ready_L2_D !== 1'b1) begin
      errors++;
      $display("FAIL wb_stable got %0d stable cycles rD=%b expected 4 1", stable, ready_L2_D);
    end
    @(negedge clk);
    ready_L2_L1 = 1'b0;
    read_D_L2   = 1'b1;
    #1;
    checks++;
    if (write_L1_L2 !== 1'b0 || read_L1_L2 !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL wb_release got wr=%b rd=%b busy=%b expected 0 0 1", write_L1_L2, read_L1_L2, busy);
    end
    @(negedge clk);
    write_D_L2 = 1'b0;
    #1;
    checks++;
    if (write_L1_L2 !== 1'b0 || read_L1_L2 !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wb_stale_write got wr=%b rd=%b busy=%b expected 0 0 0", write_L1_L2, read_L1_L2, busy);
    end
    @(negedge clk);
    r = rand_line();
    ready_L2_L1 = 1'b1;
    rdata_L2_L1 = r;
    #1;
    checks++;
    if (read_L1_L2 !== 1'b1 || write_L1_L2 !== 1'b0 || owner !== 1'b1 || ready_L2_D !== 1'b1 || data_L2_D !== r) begin
      errors++;
      $display("FAIL wb_refill got rd=%b wr=%b owner=%b rD=%b dD=%h expected 1 0 1 1 %h",
               read_L1_L2, write_L1_L2, owner, ready_L2_D, data_L2_D, r);
    end
    @(negedge clk);
    ready_L2_L1 = 1'b0;
    read_D_L2   = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wb_end got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_mid_grant();
    @(negedge clk);
    read_D_L2 = 1'b1;
    addr_D_L2 = 32'h0000_5000;
    @(negedge clk);
    addr_D_L2 = 32'hDEAD_0000;
    read_I_L2 = 1'b1;
    #1;
    checks++;
    if (addr_L1_L2 !== 32'h0000_5000 || owner !== 1'b1 || read_L1_L2 !== 1'b1) begin
      errors++;
      $display("FAIL mid_grant got addr=%h owner=%b rd=%b expected 00005000 1 1", addr_L1_L2, owner, read_L1_L2);
    end
    @(negedge clk);
    read_I_L2 = 1'b0;
    addr_D_L2 = $urandom();
    #1;
    checks++;
    if (addr_L1_L2 !== 32'h0000_5000) begin
      errors++;
      $display("FAIL mid_addr_hold got %h expected 00005000", addr_L1_L2);
    end
    @(negedge clk);
    read_I_L2   = 1'b1;
    ready_L2_L1 = 1'b1;
    rdata_L2_L1 = rand_line();
    #1;
    checks++;
    if (ready_L2_I !== 1'b0 || data_L2_I !== 128'h0 || ready_L2_D !== 1'b1 || addr_L1_L2 !== 32'h0000_5000) begin
      errors++;
      $display("FAIL mid_ready got rI=%b dI=%h rD=%b addr=%h expected 0 0 1 00005000",
               ready_L2_I, data_L2_I, ready_L2_D, addr_L1_L2);
    end
    @(negedge clk);
    ready_L2_L1 = 1'b0;
    read_I_L2   = 1'b0;
    read_D_L2   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || read_L1_L2 !== 1'b0) begin
      errors++;
      $display("FAIL mid_end got busy=%b rd=%b expected 0 0", busy, read_L1_L2);
    end
  endtask

  task automatic test_stray_ready();
    @(negedge clk);
    ready_L2_L1 = 1'b1;
    rdata_L2_L1 = rand_line();
    #1;
    checks++;
    if (ready_L2_I !== 1'b0 || ready_L2_D !== 1'b0 || data_L2_I !== 128'h0 || data_L2_D !== 128'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stray_ready got rI=%b rD=%b busy=%b expected 0 0 0", ready_L2_I, ready_L2_D, busy);
    end
    @(negedge clk);
    ready_L2_L1 = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || read_L1_L2 !== 1'b0 || write_L1_L2 !== 1'b0) begin
      errors++;
      $display("FAIL stray_after got busy=%b rd=%b wr=%b expected 0 0 0", busy, read_L1_L2, write_L1_L2);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    read_I_L2 = 1'b1;
    addr_I_L2 = 32'h0000_6000;
    @(negedge clk);
    #1;
    checks++;
    if (read_L1_L2 !== 1'b1 || owner !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_grant got rd=%b owner=%b expected 1 0", read_L1_L2, owner);
    end
    #1;
    nrst = 1'b0;
    ready_L2_L1 = 1'b1;
    rdata_L2_L1 = rand_line();
    #1;
    checks++;
    if ({read_L1_L2, write_L1_L2, busy, owner, ready_L2_I, ready_L2_D} !== 6'b000000 ||
        addr_L1_L2 !== 32'h0 || data_L2_I !== 128'h0) begin
      errors++;
      $display("FAIL rstmid_async got ctrl=%b addr=%h expected 000000 0",
               {read_L1_L2, write_L1_L2, busy, owner, ready_L2_I, ready_L2_D}, addr_L1_L2);
    end
    ready_L2_L1 = 1'b0;
    read_I_L2   = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    read_I_L2 = 1'b1;
    read_D_L2 = 1'b1;
    addr_D_L2 = 32'h0000_7000;
    @(negedge clk);
    ready_L2_L1 = 1'b1;
    #1;
    checks++;
    if (owner !== 1'b1 || addr_L1_L2 !== 32'h0000_7000 || ready_L2_D !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_tie got owner=%b addr=%h rD=%b expected 1 00007000 1", owner, addr_L1_L2, ready_L2_D);
    end
    @(negedge clk);
    drive_quiet();
    @(negedge clk);
  endtask

  task automatic test_random();
    logic m_active, m_who, m_write, m_rel, m_last, m_owner;
    logic [ADDR_W-1:0] m_addr;
    logic [LINE_W-1:0] m_wdata;
    logic exp_rdyI, exp_rdyD;
    logic [LINE_W-1:0] exp_dI, exp_dD;
    logic reqI, reqD;
    apply_reset();
    {m_active, m_who, m_write, m_rel, m_last, m_owner} = 6'b0;
    m_addr  = 32'h0;
    m_wdata = 128'h0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      nrst        = ($urandom_range(0, 249) != 0);
      read_I_L2   = $urandom_range(0, 1);
      read_D_L2   = $urandom_range(0, 1);
      write_D_L2  = ($urandom_range(0, 3) == 0);
      addr_I_L2   = $urandom();
      addr_D_L2   = $urandom();
      wdata_D_L2  = rand_line();
      ready_L2_L1 = ($urandom_range(0, 2) == 0);
      rdata_L2_L1 = rand_line();
      #1;
      if (!nrst) begin
        {m_active, m_who, m_write, m_rel, m_last, m_owner} = 6'b0;
        m_addr  = 32'h0;
        m_wdata = 128'h0;
      end
      exp_rdyI = m_active && !m_who && ready_L2_L1;
      exp_rdyD = m_active && m_who && ready_L2_L1;
      exp_dI   = (m_active && !m_who) ? rdata_L2_L1 : 128'h0;
      exp_dD   = (m_active && m_who) ? rdata_L2_L1 : 128'h0;
      checks++;
      if ({read_L1_L2, write_L1_L2, busy, owner, ready_L2_I, ready_L2_D} !==
          {m_active & ~m_write, m_active & m_write, m_active | m_rel, m_owner, exp_rdyI, exp_rdyD}) begin
        errors++;
        $display("FAIL random_ctrl cycle %0d got %b expected %b", c,
                 {read_L1_L2, write_L1_L2, busy, owner, ready_L2_I, ready_L2_D},
                 {m_active & ~m_write, m_active & m_write, m_active | m_rel, m_owner, exp_rdyI, exp_rdyD});
      end
      checks++;
      if (addr_L1_L2 !== m_addr || wdata_L1_L2 !== m_wdata) begin
        errors++;
        $display("FAIL random_latch cycle %0d got %h/%h expected %h/%h", c, addr_L1_L2, wdata_L1_L2, m_addr, m_wdata);
      end
      checks++;
      if (data_L2_I !== exp_dI || data_L2_D !== exp_dD) begin
        errors++;
        $display("FAIL random_data cycle %0d got %h/%h expected %h/%h", c, data_L2_I, data_L2_D, exp_dI, exp_dD);
      end
      if (nrst) begin
        reqI = read_I_L2;
        reqD = read_D_L2 | write_D_L2;
        if (m_active) begin
          if (ready_L2_L1) begin
            m_active = 1'b0;
            m_rel    = 1'b1;
          end
        end else if (m_rel) begin
          m_rel = 1'b0;
        end else if (reqI || reqD) begin
          m_who    = (reqI && reqD) ? !m_last : reqD;
          m_active = 1'b1;
          m_last   = m_who;
          m_owner  = m_who;
          m_write  = m_who && write_D_L2;
          m_addr   = m_who ? addr_D_L2 : addr_I_L2;
          if (m_who) m_wdata = wdata_D_L2;
        end
      end
    end
    @(negedge clk);
    nrst = 1'b1;
    drive_quiet();
  endtask

  initial begin
    nrst = 1'b0;
    drive_quiet();
    test_reset();
    test_single_i_read();
    test_tie();
    test_wb_refill();
    test_mid_grant();
    test_stray_ready();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
